// File: rtl/csa_accumulator.sv
// Streaming carry-save accumulator: one operand per beat, redundant sum/carry
// in the loop, a single carry-propagate add at packet end.
module csa_accumulator #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 16,
  parameter int SIGNED  = 0,
  localparam int LOG_OPS = $clog2(MAX_OPS),
  localparam int ACC_W   = WIDTH + LOG_OPS,
  localparam int CNT_W   = LOG_OPS + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OPS_LIM = CNT_W'(MAX_OPS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_sum_q, res_sum_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;
  logic             valid_q, valid_d;

  logic             beat;
  logic             hs;
  logic             ext_bit;
  logic [ACC_W-1:0] op;
  logic [ACC_W-1:0] csa_sum;
  logic [ACC_W-1:0] csa_carry;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign out_valid = valid_q;
  assign out_sum   = res_sum_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;

  assign beat    = in_valid && in_ready;
  assign hs      = valid_q && out_ready;
  assign ext_bit = (SIGNED != 0) && in_data[WIDTH-1];
  assign op      = {{LOG_OPS{ext_bit}}, in_data};

  // 3:2 compression of (sum, carry, op); carry weight shifts up one bit
  assign csa_sum   = sum_q ^ carry_q ^ op;
  assign csa_carry = ((sum_q & carry_q) | (sum_q & op) | (carry_q & op)) << 1;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_sum_d = res_sum_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    valid_d   = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (beat) begin
          sum_d   = op;
          carry_d = '0;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = in_last ? S_RESOLVE : S_ACCUM;
        end
      end
      (state_q == S_ACCUM): begin
        if (beat) begin
          sum_d   = csa_sum;
          carry_d = csa_carry;
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q || (cnt_q == OPS_LIM);
          state_d = in_last ? S_RESOLVE : S_ACCUM;
        end
      end
      (state_q == S_RESOLVE): begin
        res_sum_d = sum_q + carry_q;
        res_cnt_d = cnt_q;
        res_ovf_d = ovf_q;
        state_d   = S_OUTPUT;
      end
      (state_q == S_OUTPUT): begin
        // result regs settle one cycle before valid is raised
        valid_d = !hs;
        if (hs) begin
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_sum_q <= res_sum_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: unsigned and signed instances share one stream,
// checked against plain integer packet sums.
module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_u, in_ready_s;
  logic       out_valid_u, out_valid_s;
  logic [7:0] out_sum_u, out_sum_s;
  logic [4:0] out_count_u, out_count_s;
  logic       out_ovf_u, out_ovf_s;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] pkt[$];

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(4), .MAX_OPS(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_sum(out_sum_u), .out_count(out_count_u), .out_ovf(out_ovf_u)
  );

  csa_accumulator #(.WIDTH(4), .MAX_OPS(16), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input logic rdy, input logic vld);
    chk({tag, "_ready_u"}, in_ready_u, rdy);
    chk({tag, "_ready_s"}, in_ready_s, rdy);
    chk({tag, "_valid_u"}, out_valid_u, vld);
    chk({tag, "_valid_s"}, out_valid_s, vld);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] eu,
                         input logic [7:0] es, input logic [4:0] ec,
                         input logic eo);
    chk({tag, "_sum_u"}, out_sum_u, eu);
    chk({tag, "_sum_s"}, out_sum_s, es);
    chk({tag, "_cnt_u"}, out_count_u, ec);
    chk({tag, "_cnt_s"}, out_count_s, ec);
    chk({tag, "_ovf_u"}, out_ovf_u, eo);
    chk({tag, "_ovf_s"}, out_ovf_s, eo);
  endtask

  // Reference: integer sum of the packet, then the reported fields
  task automatic model(output logic [7:0] eu, output logic [7:0] es,
                       output logic [4:0] ec, output logic eo);
    int su = 0;
    int ss = 0;
    int n = pkt.size();
    foreach (pkt[i]) begin
      su += int'(pkt[i]);
      ss += pkt[i][3] ? int'(pkt[i]) - 16 : int'(pkt[i]);
    end
    eu = su[7:0];
    es = ss[7:0];
    ec = (n > 31) ? 5'd31 : n[4:0];
    eo = (n > 16);
  endtask

  // Drive pkt, then check result timing, stall stability and handshake
  task automatic run_pkt(input string tag, input int gap_pct,
                         input int stall);
    logic [7:0] eu, es;
    logic [4:0] ec;
    logic       eo;
    int n = pkt.size();
    model(eu, es, ec, eo);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(1));
        in_data  = 4'($urandom);
        @(posedge clk); #1;
        chk_hs({tag, "_gap"}, 1'b1, 1'b0);
      end
      chk_hs({tag, "_beat"}, 1'b1, 1'b0);
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == n - 1);
      @(posedge clk); #1;
    end
    // junk beats while busy must be ignored
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 4'($urandom);
    chk_hs({tag, "_resolve"}, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_hs({tag, "_lat1"}, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_hs({tag, "_lat2"}, 1'b0, 1'b1);
    chk_res(tag, eu, es, ec, eo);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk_hs({tag, "_stall"}, 1'b0, 1'b1);
      chk_res({tag, "_stall"}, eu, es, ec, eo);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_hs({tag, "_done"}, 1'b1, 1'b0);
  endtask

  initial begin
    #1;
    chk_hs("rst", 1'b1, 1'b0);
    chk_res("rst", 8'h00, 8'h00, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pkt = '{4'hB, 4'hD, 4'h6};
    run_pkt("tp1", 0, 0);
    pkt = '{4'hF, 4'hF, 4'h7};
    run_pkt("tp2", 0, 1);
    pkt = '{4'h8};
    run_pkt("single", 0, 0);

    pkt = {};
    for (int i = 0; i < 18; i++) pkt.push_back(4'hF);
    run_pkt("ovf18", 0, 0);
    pkt = {};
    for (int i = 0; i < 16; i++) pkt.push_back(4'hF);
    run_pkt("full16", 0, 0);

    pkt = '{4'h3, 4'h9, 4'hC, 4'h4};
    run_pkt("stall5", 60, 5);
    pkt = '{4'h1};
    run_pkt("clean", 0, 0);

    // reset mid-packet, asserted away from the clock edge
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = 4'h7;
    @(posedge clk); #1;
    in_data  = 4'h9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_hs("midrst", 1'b1, 1'b0);
    chk_res("midrst", 8'h00, 8'h00, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pkt = '{4'h5, 4'hA, 4'h6};
    run_pkt("postrst", 0, 0);

    for (int p = 0; p < 25; p++) begin
      int len = $urandom_range(1, 20);
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(4'($urandom));
      run_pkt("rnd", 30, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Streaming multi-operand adder. Accepts a packet of WIDTH-bit operands over a valid/ready handshake and accumulates it in carry-save (redundant sum/carry) form, one operand per cycle, with no carry propagation in the loop.
- On the packet's last beat, a single carry-propagate add resolves the result. The result is presented on an output valid/ready handshake.
- Successor to the combinational 4-bit 3:2 CSA cell, adding:
  - parametrised width and operand count
  - signed/unsigned mode
  - packet framing
  - backpressure
  - overflow detection

Parameters:
- WIDTH, 4, operand width in bits (≥2).
- MAX_OPS, 16, max operands per packet guaranteed not to overflow (power of 2, ≥2).
- SIGNED, 0, 1 = operands two's-complement (sign-extend), 0 = unsigned (zero-extend).
- Derived localparam ACC_W = WIDTH + clog2(MAX_OPS). Default is 8.
- Derived localparam CNT_W = clog2(MAX_OPS) + 1. Default is 5.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  operand.
- in_last  in  1  beat is the final operand of the packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  resolved sum, modulo 2^ACC_W.
- out_count  out  CNT_W  operands accepted in packet, saturating at 2^CNT_W-1.
- out_ovf  out  1  packet contained more than MAX_OPS operands.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - state=IDLE
  - sum_r, carry_r, out_sum, out_count = 0
  - out_ovf=0, out_valid=0
  - in_ready=1 immediately after reset.
- Beat accepted iff in_valid & in_ready at a rising edge. Operand op = in_data extended to ACC_W (sign-extend if SIGNED, else zero-extend).
- States: IDLE, ACCUM, RESOLVE, OUTPUT.
- IDLE, in_ready=1. On beat:
  - sum_r<=op, carry_r<=0, cnt<=1
  - next = RESOLVE if in_last, else ACCUM.
- ACCUM, in_ready=1. On beat:
  - sum_r <= sum_r ^ carry_r ^ op
  - carry_r <= ((sum_r&carry_r)|(sum_r&op)|(carry_r&op)) << 1, truncated to ACC_W
  - cnt <= cnt+1, saturating
  - ovf sticky set when cnt already == MAX_OPS
  - next = RESOLVE if in_last.
  - No beat: hold all state.
- RESOLVE, in_ready=0, one cycle:
  - out_sum <= sum_r + carry_r mod 2^ACC_W
  - out_count <= cnt, out_ovf <= ovf
  - next = OUTPUT.
- OUTPUT, in_ready=0, out_valid=1:
  - out_sum/out_count/out_ovf stable while out_valid & !out_ready.
  - On out_ready: clear cnt, ovf, sum_r, carry_r; next = IDLE.
  - out_valid drops the cycle after the handshake.
- Latency: last beat accepted at edge N, out_valid high after edge N+2. Minimum packet-to-packet period is packet_len + 3 cycles.
- Single-operand packet (in_last on first beat): out_sum = op, out_count=1.
- Beats presented while in_ready=0 are ignored and must be held by the source.
- out_ready is ignored outside OUTPUT.
- in_last with in_valid=0 has no effect.
- Overflow: accumulation continues modulo 2^ACC_W. out_ovf=1 reports that the count exceeded MAX_OPS; no other wrap detection.
- Reset mid-operation (any state) discards the packet and returns to the reset values within the same cycle as rst_n falls.

Test Plan:
- WIDTH=4, SIGNED=0:
  - beats 1011, 1101, 0110(last) -> out_sum=8'h1E, out_count=3, out_ovf=0, out_valid rises 2 edges after last beat.
  - beats 1111, 1111, 0111(last) -> 8'h25, count 3.
- SIGNED=1: beats 1111, 1111, 0111(last) (-1,-1,7) -> out_sum=8'h05. Beat 1000(last) alone -> 8'hF8, count 1.
- Overflow: SIGNED=0, 18 beats of 4'hF -> out_sum=8'h0E (270 mod 256), out_count=18, out_ovf=1. Exactly 16 beats of 4'hF -> 8'hF0, out_ovf=0.
- Backpressure/stall: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. Toggle in_valid off mid-packet -> no state change. Second packet after handshake starts clean (1 beat 0001 -> 8'h01).
- Reset mid-packet: after 2 beats assert rst_n=0 off-edge -> in_ready=1, out_valid=0, all outputs 0 immediately. New packet 0101, 1010, 0110(last) -> 8'h15.
